// File: rtl/fetch_align_buffer.sv
// fetch_align_buffer: per-slot kill/align of fetch packets, DEPTH-packet decoupling queue, branch flush.
// Optional macro FETCH_BYPASS_EN: an empty queue forwards the incoming packet to decode combinationally.
module fetch_align_buffer #(
  parameter int XLEN  = 32,
  parameter int SLOTS = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clock_i,
  input  logic                       reset_n_i,
  input  logic [SLOTS*XLEN-1:0]      idata_i,
  input  logic                       ivalid_i,
  output logic                       iready_o,
  input  logic [SLOTS-1:0]           slot_kill_i,
  input  logic [SLOTS-1:0]           pred_i,
  input  logic                       branch_mispred_i,
  input  logic                       wasnt_branch_i,
  output logic [SLOTS*XLEN-1:0]      inst_o,
  output logic [SLOTS-1:0]           pred_o,
  output logic [SLOTS-1:0]           valid_o,
  input  logic                       ready_i,
  output logic                       branch_flush_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);
  localparam logic [OW-1:0] OCC_ONE = OW'(1);
  localparam logic [OW-1:0] OCC_ZERO = OW'(0);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);

  logic [SLOTS*XLEN-1:0] inst_mem_r  [DEPTH];
  logic [SLOTS-1:0]      pred_mem_r  [DEPTH];
  logic [SLOTS-1:0]      valid_mem_r [DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [OW-1:0]         occ_r;
  logic                  second_flush_r;

  logic                  flush_req_s;
  logic                  flush_active_s;
  logic                  push_s;
  logic                  store_s;
  logic                  pop_s;
  logic                  mem_pop_s;
  logic                  bypass_s;
  logic [SLOTS*XLEN-1:0] in_inst_s;
  logic [SLOTS-1:0]      in_pred_s;
  logic [SLOTS-1:0]      in_valid_s;

  assign flush_req_s    = branch_mispred_i | wasnt_branch_i;
  assign flush_active_s = flush_req_s | second_flush_r;
  assign branch_flush_o = flush_active_s;
  assign occupancy_o    = occ_r;

  // Packets offered during a flush are accepted and silently discarded.
  assign iready_o   = (occ_r < DEPTH_C) | flush_active_s;
  assign push_s     = ivalid_i & iready_o & ~flush_active_s & ~(&slot_kill_i);
  assign in_valid_s = ~slot_kill_i;
  assign in_pred_s  = pred_i & ~slot_kill_i;

`ifdef FETCH_BYPASS_EN
  assign bypass_s = (occ_r == OCC_ZERO) & ~flush_active_s & push_s;
`else
  assign bypass_s = 1'b0;
`endif

  // A bypassed packet consumed by decode in the same cycle never enters the queue.
  assign pop_s     = (|valid_o) & ready_i;
  assign store_s   = push_s & ~(bypass_s & ready_i);
  assign mem_pop_s = pop_s & ~bypass_s;

  // Zero the instruction field of every killed slot.
  always_comb begin
    in_inst_s = {(SLOTS*XLEN){1'b0}};
    for (int j = 0; j < SLOTS; j++) begin
      if (slot_kill_i[j]) begin
        in_inst_s[j*XLEN +: XLEN] = {XLEN{1'b0}};
      end else begin
        in_inst_s[j*XLEN +: XLEN] = idata_i[j*XLEN +: XLEN];
      end
    end
  end

  // Head-of-queue presentation, blanked while a flush is in progress.
  always_comb begin
    inst_o  = {(SLOTS*XLEN){1'b0}};
    pred_o  = {SLOTS{1'b0}};
    valid_o = {SLOTS{1'b0}};
    if (flush_active_s) begin
      valid_o = {SLOTS{1'b0}};
    end else if (occ_r != OCC_ZERO) begin
      inst_o  = inst_mem_r[rd_ptr_r];
      pred_o  = pred_mem_r[rd_ptr_r];
      valid_o = valid_mem_r[rd_ptr_r];
    end else if (bypass_s) begin
      inst_o  = in_inst_s;
      pred_o  = in_pred_s;
      valid_o = in_valid_s;
    end else begin
      valid_o = {SLOTS{1'b0}};
    end
  end

  // Packet storage.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_r[i]  <= {(SLOTS*XLEN){1'b0}};
        pred_mem_r[i]  <= {SLOTS{1'b0}};
        valid_mem_r[i] <= {SLOTS{1'b0}};
      end
    end else if (store_s && !flush_req_s) begin
      inst_mem_r[wr_ptr_r]  <= in_inst_s;
      pred_mem_r[wr_ptr_r]  <= in_pred_s;
      valid_mem_r[wr_ptr_r] <= in_valid_s;
    end
  end

  // Second flush cycle tracker.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      second_flush_r <= 1'b0;
    end else begin
      second_flush_r <= flush_req_s;
    end
  end

  // Pointers and occupancy; a flush empties the queue and overrides any push/pop.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      occ_r    <= OCC_ZERO;
    end else if (flush_req_s) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      occ_r    <= OCC_ZERO;
    end else begin
      if (store_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (mem_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({store_s, mem_pop_s})
        2'b10:   occ_r <= occ_r + OCC_ONE;
        2'b01:   occ_r <= occ_r - OCC_ONE;
        default: occ_r <= occ_r;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Scoreboard bench for fetch_align_buffer: directed scenarios followed by randomized traffic,
// checked against a packet-queue reference model.
module tb_fetch_align_buffer;

  localparam int XLEN  = 32;
  localparam int SLOTS = 2;
  localparam int DEPTH = 4;
  localparam int CW    = SLOTS*XLEN;
  localparam int OW    = $clog2(DEPTH+1);

  typedef struct packed {
    logic [CW-1:0]    inst;
    logic [SLOTS-1:0] pred;
    logic [SLOTS-1:0] valid;
  } pkt_t;

  logic             clock_i = 1'b0;
  logic             reset_n_i = 1'b0;
  logic [CW-1:0]    idata_i = '0;
  logic             ivalid_i = 1'b0;
  logic             iready_o;
  logic [SLOTS-1:0] slot_kill_i = '0;
  logic [SLOTS-1:0] pred_i = '0;
  logic             branch_mispred_i = 1'b0;
  logic             wasnt_branch_i = 1'b0;
  logic [CW-1:0]    inst_o;
  logic [SLOTS-1:0] pred_o;
  logic [SLOTS-1:0] valid_o;
  logic             ready_i = 1'b0;
  logic             branch_flush_o;
  logic [OW-1:0]    occupancy_o;

  fetch_align_buffer #(.XLEN(XLEN), .SLOTS(SLOTS), .DEPTH(DEPTH)) dut (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .idata_i(idata_i), .ivalid_i(ivalid_i),
    .iready_o(iready_o), .slot_kill_i(slot_kill_i), .pred_i(pred_i),
    .branch_mispred_i(branch_mispred_i), .wasnt_branch_i(wasnt_branch_i), .inst_o(inst_o),
    .pred_o(pred_o), .valid_o(valid_o), .ready_i(ready_i), .branch_flush_o(branch_flush_o),
    .occupancy_o(occupancy_o)
  );

  always #5 clock_i = ~clock_i;

  pkt_t exp_q[$];
  int   occ_m = 0;
  logic sf_m = 1'b0;
  logic cur_flush = 1'b0;
  logic cur_acc = 1'b0;
  pkt_t cur_pkt = '0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Slot s occupies the s-th XLEN field from the top; its kill/pred/valid bit is SLOTS-1-s.
  function automatic pkt_t mk(input logic [CW-1:0] d, input logic [SLOTS-1:0] k,
                              input logic [SLOTS-1:0] p);
    pkt_t r;
    r = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (!k[SLOTS-1-s]) begin
        r.inst[CW-1-s*XLEN -: XLEN] = d[CW-1-s*XLEN -: XLEN];
        r.pred[SLOTS-1-s]  = p[SLOTS-1-s];
        r.valid[SLOTS-1-s] = 1'b1;
      end
    end
    return r;
  endfunction

  // One clock: commit last cycle's effect into the model at the edge, then drive new inputs.
  task automatic step(input logic iv, input logic [CW-1:0] d, input logic [SLOTS-1:0] k,
                      input logic [SLOTS-1:0] p, input logic mp, input logic wb, input logic rdy);
    logic busy;
    @(posedge clock_i);
    if (!reset_n_i) begin
      exp_q.delete();
      sf_m = 1'b0;
    end else begin
      if (cur_flush) exp_q.delete();
      else if (cur_acc) exp_q.push_back(cur_pkt);
      sf_m = cur_flush;
    end
    occ_m = exp_q.size();
    #1;
    ivalid_i = iv; idata_i = d; slot_kill_i = k; pred_i = p;
    branch_mispred_i = mp; wasnt_branch_i = wb; ready_i = rdy;
    cur_flush = mp | wb;
    busy      = cur_flush | sf_m;
    cur_pkt   = mk(d, k, p);
    cur_acc   = iv && !busy && (occ_m < DEPTH) && !(&k);
`ifdef FETCH_BYPASS_EN
    if (cur_acc && exp_q.size() == 0) begin
      exp_q.push_back(cur_pkt);
      cur_acc = 1'b0;
    end
`endif
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, '0, '0, 1'b0, 1'b0, rdy);
  endtask

  task automatic push(input logic [CW-1:0] d, input logic [SLOTS-1:0] k,
                      input logic [SLOTS-1:0] p, input logic rdy);
    step(1'b1, d, k, p, 1'b0, 1'b0, rdy);
  endtask

  // Monitor: compares the presented head against the scoreboard and retires it on handshake.
  always @(negedge clock_i) begin : monitor
    logic fl;
    logic exp_rdy;
    fl      = cur_flush | sf_m;
    exp_rdy = (occ_m < DEPTH) || fl;
    chk("branch_flush", CW'(branch_flush_o), CW'(fl));
    chk("occupancy", CW'(occupancy_o), CW'(occ_m));
    chk("iready", CW'(iready_o), CW'(exp_rdy));
    if (!fl && exp_q.size() > 0) begin
      chk("head_inst", inst_o, exp_q[0].inst);
      chk("head_pred", CW'(pred_o), CW'(exp_q[0].pred));
      chk("head_valid", CW'(valid_o), CW'(exp_q[0].valid));
      if (ready_i) void'(exp_q.pop_front());
    end else begin
      chk("idle_valid", CW'(valid_o), CW'(0));
      chk("idle_inst", inst_o, CW'(0));
      chk("idle_pred", CW'(pred_o), CW'(0));
    end
  end

  initial begin : main
    logic [CW-1:0] d;
    logic          rdy;
    #2;
    chk("rst_valid", CW'(valid_o), CW'(0));
    chk("rst_iready", CW'(iready_o), CW'(1));
    chk("rst_occ", CW'(occupancy_o), CW'(0));
    chk("rst_flush", CW'(branch_flush_o), CW'(0));
    idle(1'b0);
    idle(1'b0);
    reset_n_i = 1'b1;

`ifdef FETCH_BYPASS_EN
    push(64'h1234_5678_9ABC_DEF0, 2'b00, 2'b01, 1'b1);
    #2;
    chk("bypass_inst", inst_o, 64'h1234_5678_9ABC_DEF0);
    chk("bypass_occ", CW'(occupancy_o), CW'(0));
    idle(1'b0);
`endif

    // Basic push, one-cycle latency.
    push(64'hAAAA0001_BBBB0002, 2'b00, 2'b00, 1'b1);
    idle(1'b0);
    #2;
    chk("t1_inst", inst_o, 64'hAAAA0001_BBBB0002);
    chk("t1_valid", CW'(valid_o), CW'(2'b11));
    idle(1'b1);

    // Slot-1 kill, then a fully-killed packet that must be dropped.
    push(64'hCCCC0003_DDDD0004, 2'b01, 2'b11, 1'b0);
    idle(1'b0);
    #2;
    chk("t2_inst", inst_o, 64'hCCCC0003_00000000);
    chk("t2_pred", CW'(pred_o), CW'(2'b10));
    chk("t2_valid", CW'(valid_o), CW'(2'b10));
    push(64'hEEEE0005_FFFF0006, 2'b11, 2'b11, 1'b0);
    idle(1'b0);
    #2;
    chk("t2_drop_occ", CW'(occupancy_o), CW'(1));
    idle(1'b1);

    // Fill to DEPTH with decode stalled, then a simultaneous pop and refused push.
    for (int i = 0; i < 5; i++) push({32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i)}, 2'b00, 2'(i), 1'b0);
    #2;
    chk("t3_full_iready", CW'(iready_o), CW'(0));
    chk("t3_full_occ", CW'(occupancy_o), CW'(DEPTH));
    push(64'h3000_0000_3000_0001, 2'b00, 2'b00, 1'b1);
    idle(1'b0);
    #2;
    chk("t3_occ_after_pop", CW'(occupancy_o), CW'(DEPTH-1));
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Mispredict with traffic in flight: queue emptied, flush lasts two cycles.
    for (int i = 0; i < 3; i++) push({32'h4000_0000 + 32'(i), 32'h5000_0000}, 2'b00, 2'b00, 1'b0);
    step(1'b1, 64'h6000_0000_6000_0001, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
    #2;
    chk("t4_flush_c1", CW'(branch_flush_o), CW'(1));
    push(64'h7000_0000_7000_0001, 2'b00, 2'b00, 1'b0);
    #2;
    chk("t4_flush_c2", CW'(branch_flush_o), CW'(1));
    idle(1'b0);
    #2;
    chk("t4_flush_c3", CW'(branch_flush_o), CW'(0));
    chk("t4_occ", CW'(occupancy_o), CW'(0));
    chk("t4_valid", CW'(valid_o), CW'(0));

    // Back-to-back wasnt_branch: three flush cycles.
    step(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    #2;
    chk("t5_flush_c3", CW'(branch_flush_o), CW'(1));
    idle(1'b1);
    #2;
    chk("t5_flush_c4", CW'(branch_flush_o), CW'(0));

    // Reset during the second flush cycle clears the pending second flush.
    step(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
    step(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
    #2;
    reset_n_i = 1'b0;
    sf_m = 1'b0;
    exp_q.delete();
    occ_m = 0;
    #1;
    chk("t6_flush_in_rst", CW'(branch_flush_o), CW'(1));
    idle(1'b1);
    #2;
    chk("t6_flush_cleared", CW'(branch_flush_o), CW'(0));
    reset_n_i = 1'b1;

    // Randomized traffic with stall phases and occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      for (int s = 0; s < SLOTS; s++) d[s*XLEN +: XLEN] = $urandom();
      rdy = ((i / 150) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      step($urandom_range(0, 3) != 0, d, SLOTS'($urandom()), SLOTS'($urandom()),
           $urandom_range(0, 49) == 0, $urandom_range(0, 59) == 0, rdy);
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
    @(posedge clock_i);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_align_buffer.md
# fetch_align_buffer

Parametrised second fetch stage with decoupling queue. Splits each SLOTS-wide fetch packet from instruction memory into per-slot instructions, applies per-slot kill masks, and buffers up to DEPTH packets between fetch and decode with valid/ready handshakes. Generates the two-cycle branch flush for the front end on mispredict or false-branch events.

## Interface
- XLEN, 32: instruction width in bits.
- SLOTS, 2: instructions per fetch packet (issue width); ≥1.
- DEPTH, 4: queue depth in packets; power of two, ≥2.

- clock_i  in  1  clock, all state on rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- idata_i  in  SLOTS*XLEN  fetch packet; slot 0 = bits [SLOTS*XLEN-1 -: XLEN], slot k = next lower XLEN field.
- ivalid_i  in  1  idata_i/slot_kill_i/pred_i valid.
- iready_o  out  1  buffer accepts a packet this cycle.
- slot_kill_i  in  SLOTS  per-slot kill (1 = slot not executed).
- pred_i  in  SLOTS  per-slot branch-taken prediction.
- branch_mispred_i  in  1  mispredict resolved downstream.
- wasnt_branch_i  in  1  predicted-taken slot was not a branch.
- inst_o  out  SLOTS*XLEN  head packet, same slot ordering as idata_i.
- pred_o  out  SLOTS  head packet predictions.
- valid_o  out  SLOTS  per-slot valid of head packet.
- ready_i  in  1  decode consumes head packet.
- branch_flush_o  out  1  flush to fetch/PC logic.
- occupancy_o  out  $clog2(DEPTH+1)  packets stored.

## Operation
- flush_req = branch_mispred_i | wasnt_branch_i. Registered second_flush <= flush_req each cycle. branch_flush_o = flush_req | second_flush (combinational).
- Push: ivalid_i & iready_o & !flush_req & !second_flush & !(&slot_kill_i). Stores packet with killed slots' instruction forced to 0, pred forced 0, valid 0.
- Packet with all slots killed is dropped (handshake completes, nothing stored).
- iready_o = (occupancy_o < DEPTH) | second_flush | flush_req; packets accepted during a flush are discarded.
- Pop: (|valid_o) & ready_i; whole packet removed. Partial-slot consumption not supported.
- Head output: when occupancy_o = 0 or flush_req | second_flush, valid_o = 0, inst_o = 0, pred_o = 0.
- Simultaneous push and pop when full: pop occurs, push refused (iready_o already 0); occupancy stays DEPTH−1 next cycle.
- Flush: on flush_req edge, read/write pointers and occupancy reset to 0; any concurrent push/pop ignored.
- Pointers are log2(DEPTH) bits, wrap modulo DEPTH; occupancy tracked separately, never exceeds DEPTH.

## Timing
- Reset (reset_n_i low, async): pointers, occupancy_o, second_flush = 0; valid_o, inst_o, pred_o = 0; iready_o = 1; branch_flush_o = flush_req only.
- Without bypass: packet pushed at edge N appears on outputs after edge N (1-cycle latency).
- branch_flush_o asserted for the flush_req cycle and exactly one following cycle; back-to-back flush_req extends it.
- Reset asserted mid-flush clears second_flush immediately.

## Configuration
- FETCH_BYPASS_EN defined: when occupancy_o = 0, no flush active, and push condition holds, incoming packet (with kill applied) drives outputs combinationally; if ready_i is also 1, it is consumed without being stored (0-cycle latency). Otherwise stored as normal.
- Undefined: no combinational path idata_i → inst_o; minimum latency 1 cycle.

## Test plan
- Reset, SLOTS=2: push idata_i=0xAAAA0001_BBBB0002, kill=00, ready_i=1 → next cycle inst_o slot0=0xAAAA0001, slot1=0xBBBB0002, valid_o=11.
- Push kill=01 (slot 1 killed), pred=11 → slot1 inst=0, pred_o=10, valid_o=10; push kill=11 → nothing stored, occupancy unchanged.
- ready_i=0, push 5 packets at DEPTH=4 → iready_o falls after 4th, occupancy_o=4; raise ready_i for 1 cycle with ivalid_i=1 → occupancy 3, packets emerge in FIFO order across pointer wrap.
- Occupancy 3, pulse branch_mispred_i one cycle with ivalid_i=1 → branch_flush_o high 2 cycles, occupancy_o=0, valid_o=0, both pushed packets discarded.
- wasnt_branch_i high 2 consecutive cycles → branch_flush_o high 3 cycles; reset_n_i low during 2nd cycle → second_flush cleared asynchronously.
- With FETCH_BYPASS_EN, empty queue, ready_i=1: push packet → same-cycle inst_o equals packet, occupancy_o stays 0.
